// File: rtl/l2_rr_arbiter_pkg.sv
// Shared types, default sizes and a modular-increment helper for the L2
// round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE -> GRANT -> RELEASE -> IDLE)
//   wrap_add    : (a + b) mod n for 0 <= a, b < n. Uses an explicit compare so
//                 that non-power-of-2 requester counts (e.g. 3) never produce
//                 an out-of-range index.
package l2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  localparam int NUM_REQ_DEF = 2;
  localparam int LINE_W_DEF  = 256;
  localparam int ADDR_W_DEF  = 32;

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/l2_rr_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index with the highest priority this round
//   valid : at least one request is present
//   idx   : first requesting index found searching ptr, ptr+1, ... mod N
// Rotates the vector so ptr lands at bit 0, priority-encodes the lowest set
// bit, then un-rotates the offset back into a requester index.
module rr_picker
  import l2_rr_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [N-1:0] rot;
  int           off;

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    rot   = '0;
    valid = 1'b0;
    off   = 0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[wrap_add(int'(ptr), j, N)];
    end
    // Scan downward so the lowest set offset is the one that sticks.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        off   = j;
      end
    end
    idx = IW'(wrap_add(int'(ptr), off, N));
  end

endmodule

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing the single L2 port among NUM_REQ line-granular
// requesters (0 = I-cache, 1 = D-cache, further indices for future agents).
// One transaction is outstanding at a time: the winner's request is latched,
// driven to L2 until mem_resp, and the completion is routed back.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_read/req_write    : per-requester level-held line requests
//   req_address/req_wdata : flattened per-requester address / write line
//   req_rdata             : mem_rdata broadcast while a grant is active
//   req_resp              : one-hot single-cycle completion to the winner
//   mem_read/mem_write    : request to L2 (only asserted in GRANT)
//   mem_address/mem_wdata : latched address / line of the granted request
//   mem_rdata/mem_resp    : L2 read line and completion pulse
//   grant_id              : index of the current or last winner
//   busy                  : high in GRANT and RELEASE
//   proto_err             : sticky protocol-violation flag
module l2_rr_arbiter
  import l2_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*LINE_W-1:0]  req_wdata,
  output logic [LINE_W-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]         req_resp,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_resp,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] req_any;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              err_both, err_drop, err_stray;

  assign req_any = req_read | req_write;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req_any),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign err_both  = (state == ARB_IDLE) && pick_valid &&
                     req_read[pick_idx] && req_write[pick_idx];
  // The granted requester must hold its request until it sees req_resp,
  // including during the mem_resp cycle itself.
  assign err_drop  = (state == ARB_GRANT) && !req_any[grant_id];
  assign err_stray = (state != ARB_GRANT) && mem_resp;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:    if (pick_valid) state_nxt = ARB_GRANT;
      ARB_GRANT:   if (mem_resp)   state_nxt = ARB_RELEASE;
      ARB_RELEASE:                 state_nxt = ARB_IDLE;
      default:                     state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB_GRANT && mem_resp)
        rr_ptr <= IW'(wrap_add(int'(grant_id), 1, NUM_REQ));
      if (err_both || err_drop || err_stray)
        proto_err <= 1'b1;
    end
  end

  // NOTE: the wide address/line latches are reset too, so mem_address and
  // mem_wdata are defined from the first cycle even though they are only
  // driven out in GRANT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state == ARB_IDLE && pick_valid) begin
      grant_id <= pick_idx;
      addr_q   <= req_address[int'(pick_idx)*ADDR_W +: ADDR_W];
      wdata_q  <= req_wdata[int'(pick_idx)*LINE_W +: LINE_W];
      // Read and write together is illegal; the write is honoured.
      rd_q     <= req_read[pick_idx] && !req_write[pick_idx];
      wr_q     <= req_write[pick_idx];
    end
  end

  always_comb begin
    req_rdata   = '0;
    req_resp    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    busy        = (state != ARB_IDLE);
    if (state == ARB_GRANT) begin
      mem_read    = rd_q;
      mem_write   = wr_q;
      mem_address = addr_q;
      mem_wdata   = wdata_q;
      req_rdata   = mem_rdata;
      if (mem_resp) req_resp[grant_id] = 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_rr_arbiter.sv
module tb_l2_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int GW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_read, req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*LW-1:0]   req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [N-1:0]      req_resp;
  logic              mem_read, mem_write;
  logic [AW-1:0]     mem_address;
  logic [LW-1:0]     mem_wdata, mem_rdata;
  logic              mem_resp;
  logic [GW-1:0]     grant_id;
  logic              busy, proto_err;

  int errors = 0;
  int checks = 0;

  // Reference model: pending requests per requester, the requester that has
  // top priority next, and the expected sticky error flag.
  bit          pend_rd[N];
  bit          pend_wr[N];
  logic [AW-1:0] addr_m[N];
  logic [LW-1:0] wdata_m[N];
  int          model_ptr;
  bit          exp_err;

  l2_rr_arbiter #(.NUM_REQ(N), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_rdata   (req_rdata),
    .req_resp    (req_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .grant_id    (grant_id),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // First pending requester in round-robin order from model_ptr.
  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (model_ptr + i) % N;
      if (pend_rd[k] || pend_wr[k]) return k;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_read[i]               = pend_rd[i];
      req_write[i]              = pend_wr[i];
      req_address[i*AW +: AW]   = addr_m[i];
      req_wdata[i*LW +: LW]     = wdata_m[i];
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = '1;
    for (int i = 0; i < N; i++) begin
      pend_rd[i] = 0; pend_wr[i] = 0; addr_m[i] = '0; wdata_m[i] = '0;
    end
    apply();
    model_ptr = 0;
    exp_err   = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read, mem_write, busy, proto_err, |req_resp, |grant_id,
         |mem_address, |mem_wdata, |req_rdata} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b busy=%b err=%b resp=%b gid=%0d addr=%h wdata|=%b rdata|=%b, all must be 0",
               mem_read, mem_write, busy, proto_err, req_resp, grant_id,
               mem_address, |mem_wdata, |req_rdata);
    end
    mem_rdata = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Serve one transaction as the L2: wait for the grant predicted by the
  // model, check the request, respond after lat cycles, check completion and
  // the release cycle. lows = idle negedges seen before the grant appeared.
  task automatic serve(input int lat, input logic [LW-1:0] rdv,
                       input bit scramble, input bit drop_early,
                       output int got, output int lows);
    int            e;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    bit            erd, ewr;
    logic [N-1:0]  oh;
    got  = -1;
    lows = 0;
    e = model_pick();
    checks++;
    if (e < 0) begin
      errors++;
      $display("FAIL serve_setup: no pending request in model, need >= 1");
      return;
    end
    ea  = addr_m[e];
    ewd = wdata_m[e];
    ewr = pend_wr[e];
    erd = pend_rd[e] && !pend_wr[e];
    if (pend_rd[e] && pend_wr[e]) exp_err = 1;
    oh    = '0;
    oh[e] = 1'b1;

    @(negedge clk);
    while (!(mem_read || mem_write) && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    checks++;
    if (lows >= 20) begin
      errors++;
      $display("FAIL grant_timeout: no mem request within 20 cycles, expected grant to %0d", e);
      return;
    end
    got = int'(grant_id);
    checks++;
    if (grant_id !== GW'(e)) begin
      errors++; $display("FAIL grant_id: got %0d expected %0d", grant_id, e);
    end
    checks++;
    if ({mem_read, mem_write} !== {erd, ewr}) begin
      errors++; $display("FAIL mem_cmd: rd/wr got %b%b expected %b%b", mem_read, mem_write, erd, ewr);
    end
    checks++;
    if (mem_address !== ea) begin
      errors++; $display("FAIL mem_address: got %h expected %h", mem_address, ea);
    end
    checks++;
    if (mem_wdata !== ewd) begin
      errors++; $display("FAIL mem_wdata: got %h expected %h", mem_wdata, ewd);
    end
    checks++;
    if (busy !== 1'b1 || req_resp !== '0) begin
      errors++; $display("FAIL grant_status: busy=%b resp=%b expected busy=1 resp=0", busy, req_resp);
    end
    checks++;
    if (proto_err !== exp_err) begin
      errors++; $display("FAIL proto_err_grant: got %b expected %b", proto_err, exp_err);
    end

    if (scramble) begin
      addr_m[e]  = ~ea;
      wdata_m[e] = ~ewd;
      apply();
    end
    if (drop_early) begin
      pend_rd[e] = 0;
      pend_wr[e] = 0;
      apply();
      exp_err = 1;
    end

    repeat (lat) @(posedge clk);
    #1;
    checks++;
    if ({mem_read, mem_write} !== {erd, ewr} || mem_address !== ea || mem_wdata !== ewd) begin
      errors++;
      $display("FAIL grant_hold: rd/wr=%b%b addr=%h wdata_ok=%b expected %b%b %h 1",
               mem_read, mem_write, mem_address, mem_wdata === ewd, erd, ewr, ea);
    end
    mem_resp  = 1'b1;
    mem_rdata = rdv;
    #2;
    checks++;
    if (req_resp !== oh) begin
      errors++; $display("FAIL req_resp: got %b expected %b", req_resp, oh);
    end
    checks++;
    if (req_rdata !== rdv) begin
      errors++; $display("FAIL req_rdata: got %h expected %h", req_rdata, rdv);
    end

    @(posedge clk); #1;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    pend_rd[e] = 0;
    pend_wr[e] = 0;
    apply();
    model_ptr = (e + 1) % N;

    @(negedge clk);
    checks++;
    if (req_resp !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL release: resp=%b rd=%b wr=%b busy=%b expected 0 0 0 1",
               req_resp, mem_read, mem_write, busy);
    end
    checks++;
    if (proto_err !== exp_err) begin
      errors++; $display("FAIL proto_err_release: got %b expected %b", proto_err, exp_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_read();
    int got, lows;
    do_reset();
    pend_rd[1] = 1;
    addr_m[1]  = 32'h0000_1040;
    wdata_m[1] = rand_line();
    apply();
    serve(5, {32{8'hA5}}, 0, 0, got, lows);
    checks++;
    if (lows !== 1) begin
      errors++; $display("FAIL single_latency: idle cycles before grant %0d expected 1", lows);
    end
  endtask

  task automatic test_simultaneous();
    int got, lows;
    do_reset();
    pend_rd[0] = 1; addr_m[0] = 32'h100;
    pend_rd[1] = 1; addr_m[1] = 32'h200;
    apply();
    serve(2, rand_line(), 0, 0, got, lows);
    checks++;
    if (got !== 0) begin
      errors++; $display("FAIL simul_first: winner %0d expected 0", got);
    end
    // Release cycle already checked inside serve; one idle cycle follows.
    serve(1, rand_line(), 0, 0, got, lows);
    checks++;
    if (got !== 1 || lows !== 1) begin
      errors++; $display("FAIL simul_second: winner %0d idle %0d expected 1 and 1", got, lows);
    end
  endtask

  task automatic test_fairness();
    int got, lows;
    do_reset();
    pend_rd[0] = 1; addr_m[0] = 32'h1000;
    pend_rd[1] = 1; addr_m[1] = 32'h2000;
    apply();
    for (int k = 0; k < 6; k++) begin
      serve($urandom_range(0, 3), rand_line(), 0, 0, got, lows);
      checks++;
      if (got !== k % 2) begin
        errors++; $display("FAIL fairness[%0d]: winner %0d expected %0d", k, got, k % 2);
      end
      // The winner immediately asks again; it must still lose to the other.
      if (got >= 0) begin
        pend_rd[got] = 1;
        addr_m[got]  = $urandom & ~32'h1F;
        apply();
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int got, lows, any;
    do_reset();
    for (int r = 0; r < 24; r++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (!(pend_rd[i] || pend_wr[i]) && $urandom_range(0, 1) == 1) begin
          pend_wr[i] = $urandom_range(0, 1);
          pend_rd[i] = !pend_wr[i];
          addr_m[i]  = $urandom & ~32'h1F;
          wdata_m[i] = rand_line();
        end
        if (pend_rd[i] || pend_wr[i]) any = 1;
      end
      if (any == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        pend_rd[i] = 1;
        addr_m[i]  = $urandom & ~32'h1F;
      end
      apply();
      serve($urandom_range(0, 4), rand_line(), 0, 0, got, lows);
    end
  endtask

  task automatic test_write_back();
    int got, lows;
    do_reset();
    pend_wr[1] = 1;
    addr_m[1]  = 32'h0000_3FE0;
    wdata_m[1] = {8{32'hDEAD_BEEF}};
    apply();
    // Requester changes its inputs mid-GRANT; the latched copy must hold.
    serve(3, rand_line(), 1, 0, got, lows);
  endtask

  task automatic test_proto_errors();
    int got, lows;
    do_reset();
    pend_rd[0] = 1;
    pend_wr[0] = 1;
    addr_m[0]  = 32'h40;
    wdata_m[0] = rand_line();
    apply();
    serve(2, rand_line(), 0, 0, got, lows);
    @(negedge clk);
    #1;
    mem_resp = 1'b1;
    #1;
    checks++;
    if (req_resp !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL stray_idle: resp=%b busy=%b expected 0 0", req_resp, busy);
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err);
    end

    // Stray response alone, from a clean state.
    do_reset();
    #1;
    mem_resp = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stray_flag: err=%b busy=%b expected 1 0", proto_err, busy);
    end

    // Granted requester drops early: transaction still completes normally.
    do_reset();
    pend_rd[1] = 1;
    addr_m[1]  = 32'h880;
    apply();
    serve(2, rand_line(), 0, 1, got, lows);
  endtask

  task automatic test_reset_mid_grant();
    int got, lows, waited;
    do_reset();
    pend_rd[0] = 1; addr_m[0] = 32'h500;
    apply();
    serve(1, rand_line(), 0, 0, got, lows);
    pend_rd[0] = 1; addr_m[0] = 32'h600;
    pend_rd[1] = 1; addr_m[1] = 32'h700;
    apply();
    waited = 0;
    @(negedge clk);
    while (!mem_read && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (grant_id !== GW'(1) || mem_read !== 1'b1) begin
      errors++; $display("FAIL pre_reset_grant: gid=%0d rd=%b expected 1 1", grant_id, mem_read);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || req_resp !== '0) begin
      errors++;
      $display("FAIL async_reset: rd=%b busy=%b gid=%0d resp=%b expected 0 0 0 0",
               mem_read, busy, grant_id, req_resp);
    end
    @(posedge clk); #1;
    reset_n   = 1'b1;
    model_ptr = 0;
    exp_err   = 0;
    serve(2, rand_line(), 0, 0, got, lows);
    checks++;
    if (got !== 0) begin
      errors++; $display("FAIL post_reset_winner: got %0d expected 0", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write_back();
    test_proto_errors();
    test_reset_mid_grant();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
